fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

Single-clock round-robin arbiter that shares the write port of the `fifo` block among `N_REQ` producers. It runs in the FIFO write-clock domain and drives the FIFO's `buf_in` and `wr_en`. It observes `full` for backpressure. Each producer receives bounded bursts so that no producer can starve the others.

## Interface
Parameters:
- `DATA_W`, 8: word width; matches the FIFO data width.
- `N_REQ`, 4: number of requesters, 2..8.
- `BURST`, 4: maximum words accepted per grant, 1..16.
- `ID_W`, 2: width of `grant_id`; equals clog2(`N_REQ`).

Ports:
- `clk`  input  1  FIFO write clock; all logic on the rising edge.
- `rst`  input  1  Reset; asynchronous, active-high.
- `req`  input  N_REQ  Per-requester "word available". Hold high with data stable until acked.
- `req_data`  input  N_REQ*DATA_W  Requester i's word is at bits [i*DATA_W +: DATA_W].
- `full`  input  1  FIFO full flag.
- `ack`  output  N_REQ  One-hot. `ack[i]`=1 means requester i's word is written at this edge.
- `buf_in`  output  DATA_W  Data to FIFO.
- `wr_en`  output  1  Write strobe to FIFO.
- `grant_id`  output  ID_W  Current owner index.
- `busy`  output  1  High while in GRANT.

## Operation
- Registered state: `state` (IDLE/GRANT), `owner`, `beat` (0..BURST-1), `rr_ptr`.
- Combinational outputs:
  - `wr_en = (state==GRANT) & req[owner] & ~full`
  - `ack = wr_en ? (1<<owner) : 0`
  - `buf_in = wr_en ? req_data[owner] : 0`
  - `grant_id = owner`
  - `busy = (state==GRANT)`
- Selection function `pick(p)`: first index i with `req[i]`=1, scanning p, p+1, … with wrap modulo N_REQ.
- IDLE:
  - If `|req`, go to GRANT with owner=`pick(rr_ptr)` and beat=0.
  - Otherwise stay in IDLE.
- GRANT, release conditions:
  - (a) `req[owner]`=0, with no write this cycle.
  - (b) `wr_en`=1 and beat==BURST-1, so the last word is written this cycle.
- GRANT, on release:
  - Set rr_ptr=(owner+1) mod N_REQ.
  - Let P be the requests seen at the release edge, excluding `req[owner]` in case (a).
  - If P is non-empty, re-grant on the same edge: owner=`pick` over P starting at owner+1, beat=0, stay in GRANT. The old owner may win again only if it is the sole remaining requester.
  - If P is empty, go to IDLE.
- GRANT, no release:
  - If `wr_en`, beat increments.
  - If `full`, nothing changes and the grant is held indefinitely with no timeout.
- `full` and `wr_en` are never high together, so the FIFO is never overwritten.
- Indices wrap modulo N_REQ. `beat` never exceeds BURST-1.

## Timing
- Reset values: state=IDLE, owner=0, beat=0, rr_ptr=0. Therefore `wr_en`=0, `ack`=0, `buf_in`=0, `grant_id`=0, `busy`=0.
- Reset is effective immediately on assertion, regardless of phase.
- Reset mid-burst drops the grant with no write; the requester keeps its req high and is re-arbitrated after reset.
- Latency from first `req` in IDLE to first `wr_en` is 1 cycle.
- Back-to-back bursts have zero idle cycles between them.
- Throughput is 1 word per cycle while `full`=0 and the owner's req is high.
- `full` rising takes effect in the same cycle (combinational gating).
- Requester handshake: data transfers at the edge where `ack[i]`=1. The requester updates data or drops req after that edge.

## Test plan
- Single requester, BURST=4: req[0] held for 6 words (0x0C, 0x18, 0x02, 0x04, 0x00, 0x55).
  - Required: wr_en=1 for 6 consecutive cycles starting 1 cycle after req, with no gap at the burst boundary.
  - Required: FIFO counter reaches 6 and buf_out order matches.
- All 4 requesters continuously requesting.
  - Required: grant_id sequence 0,1,2,3,0 with 4 acks each.
  - Required: each requester's ack count differs by at most BURST at any time.
- Backpressure: `full` forced high for 5 cycles mid-burst of requester 2 (beat=1).
  - Required: wr_en=0 and ack=0 during the stall, with grant_id and beat held at 2 and 1.
  - Required: after `full` drops, exactly 3 more words are written before rotation.
- Early release: req[1] drops after 2 acks while req[3] is pending.
  - Required: the next edge grants 3 and rr_ptr=2.
  - Required: no spurious write in the drop cycle.
- Async reset asserted mid-burst between clock edges.
  - Required: wr_en, ack, and busy go to 0 immediately.
  - Required: after release of `rst`, arbitration restarts from index 0.

Source files
------------

// File: rtl/fifo_write_arbiter_if.sv
// Write-side bundle between N_REQ producers, the round-robin arbiter and the FIFO write port.
// The master modport is the arbiter; the slave modport is the producers plus the FIFO.
interface fifo_write_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int N_REQ  = 4,
    parameter int ID_W   = 2
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic                    full;
    logic [N_REQ-1:0]        ack;
    logic [DATA_W-1:0]       buf_in;
    logic                    wr_en;
    logic [ID_W-1:0]         grant_id;
    logic                    busy;

    modport master (
        input  req, req_data, full,
        output ack, buf_in, wr_en, grant_id, busy
    );

    modport slave (
        output req, req_data, full,
        input  ack, buf_in, wr_en, grant_id, busy
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers,
// granting bounded bursts of up to BURST words and stalling on full.
module fifo_write_arbiter #(
    parameter int DATA_W = 8,
    parameter int N_REQ  = 4,
    parameter int BURST  = 4,
    parameter int ID_W   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_write_arbiter_if.master bus
);
    localparam int BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              wr_en;
    logic              release_grant;
    logic [DATA_W-1:0] words [N_REQ];

    function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] idx);
        return (int'(idx) == N_REQ - 1) ? '0 : idx + 1'b1;
    endfunction

    // First requesting index scanning upward from start, wrapping modulo N_REQ.
    function automatic logic [ID_W-1:0] pick(input logic [N_REQ-1:0] pool,
                                             input logic [ID_W-1:0]  start);
        logic [ID_W-1:0] result;
        logic            found;
        int              idx;
        result = start;
        found  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(start) + i) % N_REQ;
            if (!found && pool[ID_W'(idx)]) begin
                result = ID_W'(idx);
                found  = 1'b1;
            end
        end
        return result;
    endfunction

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            words[i] = bus.req_data[i*DATA_W +: DATA_W];
        end
    end

    // full gates the strobe combinationally so a stall takes effect in the same cycle.
    assign wr_en        = (state_q == GRANT) && bus.req[owner_q] && !bus.full;
    assign bus.wr_en    = wr_en;
    assign bus.ack      = wr_en ? (N_REQ'(1) << owner_q) : '0;
    assign bus.buf_in   = wr_en ? words[owner_q] : '0;
    assign bus.grant_id = owner_q;
    assign bus.busy     = (state_q == GRANT);

    assign release_grant = !bus.req[owner_q] || (wr_en && (beat_q == LAST_BEAT));

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        owner_d  = owner_q;
        beat_d   = beat_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d = GRANT;
                    owner_d = pick(bus.req, rr_ptr_q);
                    beat_d  = '0;
                end
            end
            GRANT: begin
                if (release_grant) begin
                    // On a req drop the owner's bit is already clear, so req is the remaining pool.
                    rr_ptr_d = next_idx(owner_q);
                    beat_d   = '0;
                    if (|bus.req) begin
                        owner_d = pick(bus.req, next_idx(owner_q));
                    end else begin
                        state_d = IDLE;
                    end
                end else if (wr_en) begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            beat_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values together.
            state_q  <= state_d;
            owner_q  <= owner_d;
            beat_q   <= beat_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: per-requester word queues model the producers,
// and every written word is logged in order to stand in for the FIFO contents.
module tb_fifo_write_arbiter;
    localparam int DATA_W = 8;
    localparam int N_REQ  = 4;
    localparam int BURST  = 4;
    localparam int ID_W   = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fifo_write_arbiter_if #(.DATA_W(DATA_W), .N_REQ(N_REQ), .ID_W(ID_W)) bus ();

    fifo_write_arbiter #(.DATA_W(DATA_W), .N_REQ(N_REQ), .BURST(BURST), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W-1:0] words [N_REQ][$];
    logic [DATA_W-1:0] fifo_q [$];
    int                ack_cnt [N_REQ];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic drive_reqs();
        logic [N_REQ-1:0]        r;
        logic [N_REQ*DATA_W-1:0] d;
        r = '0;
        d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (words[i].size() != 0) begin
                r[i] = 1'b1;
                d[i*DATA_W +: DATA_W] = words[i][0];
            end
        end
        bus.req      = r;
        bus.req_data = d;
    endtask

    // Sample the handshake before the edge, apply it after the edge, re-drive, settle.
    task automatic tick();
        logic [N_REQ-1:0]  a;
        logic              w;
        logic [DATA_W-1:0] b;
        a = bus.ack;
        w = bus.wr_en;
        b = bus.buf_in;
        @(posedge clk);
        #1;
        for (int i = 0; i < N_REQ; i++) begin
            if (a[i]) begin
                void'(words[i].pop_front());
                ack_cnt[i]++;
            end
        end
        if (w) fifo_q.push_back(b);
        drive_reqs();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.full = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            words[i].delete();
            ack_cnt[i] = 0;
        end
        fifo_q.delete();
        drive_reqs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DATA_W-1:0] exp1 [6];
        int                g, mx, mn;
        exp1 = '{8'h0C, 8'h18, 8'h02, 8'h04, 8'h00, 8'h55};

        // Reset state with every requester asserting.
        bus.full     = 1'b0;
        bus.req      = 4'hF;
        bus.req_data = 32'hA5A5_A5A5;
        #3 rst = 1'b1;
        #1;
        check("rst_wr_en",    32'(bus.wr_en),    32'd0);
        check("rst_ack",      32'(bus.ack),      32'd0);
        check("rst_buf_in",   32'(bus.buf_in),   32'd0);
        check("rst_grant_id", 32'(bus.grant_id), 32'd0);
        check("rst_busy",     32'(bus.busy),     32'd0);
        @(posedge clk);
        #1;
        check("rst_busy_edge", 32'(bus.busy), 32'd0);

        // Single requester, six words across a burst boundary.
        do_reset();
        for (int k = 0; k < 6; k++) words[0].push_back(exp1[k]);
        drive_reqs();
        #1;
        check("t1_idle_wr_en", 32'(bus.wr_en), 32'd0);
        tick();
        for (int k = 0; k < 6; k++) begin
            check($sformatf("t1_wr_en_%0d", k),  32'(bus.wr_en),  32'd1);
            check($sformatf("t1_buf_in_%0d", k), 32'(bus.buf_in), 32'(exp1[k]));
            tick();
        end
        check("t1_done_wr_en", 32'(bus.wr_en), 32'd0);
        check("t1_fifo_count", 32'(fifo_q.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < fifo_q.size()) check($sformatf("t1_fifo_%0d", k), 32'(fifo_q[k]), 32'(exp1[k]));
        end
        tick();
        check("t1_idle_busy", 32'(bus.busy), 32'd0);

        // All four requesters continuously requesting.
        do_reset();
        for (int i = 0; i < N_REQ; i++)
            for (int j = 0; j < 8; j++) words[i].push_back(8'(i * 16 + j));
        drive_reqs();
        #1;
        tick();
        for (int k = 0; k < 16; k++) begin
            g = k / 4;
            check($sformatf("t2_grant_%0d", k), 32'(bus.grant_id), 32'(g));
            check($sformatf("t2_ack_%0d", k),   32'(bus.ack),      32'(1 << g));
            check($sformatf("t2_buf_%0d", k),   32'(bus.buf_in),   32'(g * 16 + k % 4));
            tick();
            mx = ack_cnt[0];
            mn = ack_cnt[0];
            for (int i = 1; i < N_REQ; i++) begin
                if (ack_cnt[i] > mx) mx = ack_cnt[i];
                if (ack_cnt[i] < mn) mn = ack_cnt[i];
            end
            check($sformatf("t2_spread_%0d", k), 32'(mx - mn <= BURST), 32'd1);
        end
        check("t2_wrap_grant", 32'(bus.grant_id), 32'd0);
        check("t2_wrap_buf",   32'(bus.buf_in),   32'h04);
        for (int i = 0; i < N_REQ; i++) check($sformatf("t2_acks_%0d", i), 32'(ack_cnt[i]), 32'd4);

        // Backpressure on requester 2 at beat 1, requester 3 waiting.
        do_reset();
        for (int j = 0; j < 6; j++) words[2].push_back(8'h20 + 8'(j));
        for (int j = 0; j < 4; j++) words[3].push_back(8'h30 + 8'(j));
        drive_reqs();
        #1;
        tick();
        check("t3_first_grant", 32'(bus.grant_id), 32'd2);
        tick();
        bus.full = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t3_stall_wr_en_%0d", k), 32'(bus.wr_en),    32'd0);
            check($sformatf("t3_stall_ack_%0d", k),   32'(bus.ack),      32'd0);
            check($sformatf("t3_stall_grant_%0d", k), 32'(bus.grant_id), 32'd2);
            tick();
        end
        bus.full = 1'b0;
        #1;
        for (int k = 1; k < 4; k++) begin
            check($sformatf("t3_resume_grant_%0d", k), 32'(bus.grant_id), 32'd2);
            check($sformatf("t3_resume_buf_%0d", k),   32'(bus.buf_in),   32'h20 + 32'(k));
            tick();
        end
        check("t3_rotate_grant", 32'(bus.grant_id), 32'd3);
        check("t3_rotate_buf",   32'(bus.buf_in),   32'h30);

        // Early release: requester 1 drops after two words, requester 3 pending.
        do_reset();
        words[1].push_back(8'h11);
        words[1].push_back(8'h12);
        for (int j = 0; j < 4; j++) words[3].push_back(8'h30 + 8'(j));
        drive_reqs();
        #1;
        tick();
        check("t4_grant_1", 32'(bus.grant_id), 32'd1);
        tick();
        check("t4_second_buf", 32'(bus.buf_in), 32'h12);
        tick();
        check("t4_drop_wr_en", 32'(bus.wr_en),    32'd0);
        check("t4_drop_ack",   32'(bus.ack),      32'd0);
        check("t4_drop_grant", 32'(bus.grant_id), 32'd1);
        tick();
        check("t4_regrant",  32'(bus.grant_id),   32'd3);
        check("t4_wr_en",    32'(bus.wr_en),      32'd1);
        check("t4_rr_ptr",   32'(dut.rr_ptr_q),   32'd2);

        // Asynchronous reset mid-burst, then restart from index 0.
        do_reset();
        words[0].push_back(8'hA0);
        for (int j = 0; j < 6; j++) words[2].push_back(8'hB0 + 8'(j));
        drive_reqs();
        #1;
        tick();
        check("t5_grant_0", 32'(bus.buf_in), 32'hA0);
        tick();
        tick();
        check("t5_grant_2", 32'(bus.grant_id), 32'd2);
        tick();
        tick();
        words[0].push_back(8'hC0);
        words[1].push_back(8'hD0);
        drive_reqs();
        #1;
        check("t5_mid_burst_buf", 32'(bus.buf_in), 32'hB2);
        #1 rst = 1'b1;
        #1;
        check("t5_async_wr_en", 32'(bus.wr_en), 32'd0);
        check("t5_async_ack",   32'(bus.ack),   32'd0);
        check("t5_async_busy",  32'(bus.busy),  32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_post_rst_busy", 32'(bus.busy), 32'd0);
        tick();
        check("t5_restart_grant", 32'(bus.grant_id), 32'd0);
        check("t5_restart_buf",   32'(bus.buf_in),   32'hC0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
